// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  mem_arbiter_if
//  Bundles the two requester ports (C and D), the RAM-side bus and the owner
//  flag shared by mem_arbiter and whatever sits around it.
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // Port C (CPU core)
  logic          c_req;
  logic          c_we;
  logic          c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  // Port D (loader / debug master)
  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  // RAM side
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  // Port of the most recent grant
  logic          owner;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_lock, c_addr, c_wdata,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    output owner
  );

  // Requesters plus RAM view
  modport master (
    output c_req, c_we, c_lock, c_addr, c_wdata,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  mem_arbiter
//  Two-port round-robin arbiter with bounded lock in front of a synchronous
//  single-port RAM (1-cycle read latency). One access issued per clock.
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,   // asynchronous, active-low
  mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_C = 2'd1,
    S_OWN_D = 2'd2
  } state_t;

  localparam int                  c_cnt_w    = $clog2(MAX_LOCK + 1);
  localparam logic [c_cnt_w-1:0]  c_max_lock = c_cnt_w'(MAX_LOCK);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_d;     // 1 when D received the most recent grant
  logic               r_lock_q;     // lock request captured with the last grant
  logic [c_cnt_w-1:0] r_lock_cnt;   // locked re-grants while the other port waits
  logic               r_owner;

  logic               r_m_en;
  logic               r_m_we;
  logic [AW-1:0]      r_m_addr;
  logic [DW-1:0]      r_m_wdata;

  logic               r_rv_c;
  logic               r_rv_d;

  logic               w_gnt_c;
  logic               w_gnt_d;
  logic               w_gnt_any;
  logic               w_regrant;

  // Grant decision and next state from requests, lock and registered ownership.
  // Grants are held low while reset is asserted so all outputs drop at once.
  always_comb begin
    w_gnt_c     = 1'b0;
    w_gnt_d     = 1'b0;
    w_regrant   = 1'b0;
    w_state_nxt = S_IDLE;
    if (rst) begin
      if (bus.c_req && bus.d_req) begin
        if (r_state == S_OWN_C && r_lock_q && r_lock_cnt < c_max_lock) begin
          w_gnt_c   = 1'b1;
          w_regrant = 1'b1;
        end else if (r_state == S_OWN_D && r_lock_q && r_lock_cnt < c_max_lock) begin
          w_gnt_d   = 1'b1;
          w_regrant = 1'b1;
        end else if (r_last_d) begin
          w_gnt_c = 1'b1;
        end else begin
          w_gnt_d = 1'b1;
        end
      end else if (bus.c_req) begin
        w_gnt_c = 1'b1;
      end else if (bus.d_req) begin
        w_gnt_d = 1'b1;
      end
    end
    if (w_gnt_c) begin
      w_state_nxt = S_OWN_C;
    end else if (w_gnt_d) begin
      w_state_nxt = S_OWN_D;
    end
  end

  assign w_gnt_any = w_gnt_c | w_gnt_d;

  // Ownership state, round-robin pointer, lock capture and lock counter.
  // The counter only advances on a locked re-grant under contention; any
  // other grant (handover or uncontested) and idle cycles clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b1;
      r_lock_q   <= 1'b0;
      r_lock_cnt <= '0;
      r_owner    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_regrant ? r_lock_cnt + c_cnt_w'(1) : '0;
      if (w_gnt_any) begin
        r_last_d <= w_gnt_d;
        r_owner  <= w_gnt_d;
        r_lock_q <= w_gnt_c ? bus.c_lock : bus.d_lock;
      end else begin
        r_lock_q <= 1'b0;
      end
    end
  end

  // Issue stage: register the granted port's access onto the RAM bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_m_en <= w_gnt_any;
      r_m_we <= w_gnt_any & (w_gnt_c ? bus.c_we : bus.d_we);
      if (w_gnt_any) begin
        r_m_addr  <= w_gnt_c ? bus.c_addr  : bus.d_addr;
        r_m_wdata <= w_gnt_c ? bus.c_wdata : bus.d_wdata;
      end
    end
  end

  // Return stage: a read issued last cycle comes back to the port that owns
  // the issue slot (owner was updated together with the issue registers).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rv_c <= 1'b0;
      r_rv_d <= 1'b0;
    end else begin
      r_rv_c <= r_m_en & ~r_m_we & ~r_owner;
      r_rv_d <= r_m_en & ~r_m_we &  r_owner;
    end
  end

  assign bus.c_gnt    = w_gnt_c;
  assign bus.d_gnt    = w_gnt_d;
  assign bus.m_en     = r_m_en;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.owner    = r_owner;
  assign bus.c_rvalid = r_rv_c;
  assign bus.d_rvalid = r_rv_d;
  assign bus.c_rdata  = r_rv_c ? bus.m_rdata : '0;
  assign bus.d_rdata  = r_rv_d ? bus.m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  tb_mem_arbiter
//  Self-checking bench: directed vector table, random traffic against a
//  transaction-level reference model, and an asynchronous reset sequence.
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_arbiter #(.AW(16), .DW(8), .MAX_LOCK(MAXL)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM model: write-first, 1-cycle read latency ----------
  logic [7:0] ram     [0:65535];
  bit         ram_vld [0:65535];
  logic [7:0] ram_q = 8'h00;

  function automatic logic [7:0] init_val(input int a);
    if (a == 16) return 8'h5A;
    return 8'(a ^ (a >> 8) ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        ram[bus.m_addr]     <= bus.m_wdata;
        ram_vld[bus.m_addr] <= 1'b1;
        ram_q               <= bus.m_wdata;
      end else begin
        ram_q <= ram_vld[bus.m_addr] ? ram[bus.m_addr] : init_val(int'(bus.m_addr));
      end
    end
  end
  assign bus.m_rdata = ram_q;

  // ---------------- scoring ----------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model --------------------------------------
  // Transaction view: who holds the memory, how many locked re-grants in a
  // row, who won last, and a shadow copy of memory updated in grant order.
  typedef struct {
    bit         v;
    bit         port;   // 0 = C, 1 = D
    bit         we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rexp;
  } iss_t;

  int         m_holder;     // 0 none, 1 C, 2 D (grant of the previous cycle)
  bit         m_hold_lock;
  int         m_streak;
  int         m_last;       // 1 C, 2 D
  bit         m_owner;
  logic [7:0] shadow [0:65535];
  iss_t       hist[$];      // hist[0]: two cycles ago, hist[1]: last cycle

  task automatic model_reset();
    iss_t z;
    z = '{v: 1'b0, port: 1'b0, we: 1'b0, addr: 16'h0, wdata: 8'h0, rexp: 8'h0};
    m_holder    = 0;
    m_hold_lock = 1'b0;
    m_streak    = 0;
    m_last      = 2;
    m_owner     = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endtask

  function automatic int model_pick(input bit cr, input bit dr);
    if (cr && !dr) return 1;
    if (dr && !cr) return 2;
    if (!cr && !dr) return 0;
    if (m_holder != 0 && m_hold_lock && m_streak < MAXL) return m_holder;
    return (m_last == 1) ? 2 : 1;
  endfunction

  // One clock: inputs already driven at the falling edge; compare, advance.
  task automatic step(output int g, output logic [1:0] ag);
    iss_t e1, e2, ne;
    bit   rc, rd, both;
    #1;
    both = bus.c_req && bus.d_req;
    g    = model_pick(bus.c_req, bus.d_req);
    ag   = {bus.d_gnt, bus.c_gnt};
    chk("c_gnt", bus.c_gnt, g == 1);
    chk("d_gnt", bus.d_gnt, g == 2);
    chk("owner", bus.owner, m_owner);
    e1 = hist[1];
    e2 = hist[0];
    chk("m_en", bus.m_en, e1.v);
    if (e1.v) begin
      chk("m_we",    bus.m_we,    e1.we);
      chk("m_addr",  bus.m_addr,  e1.addr);
      chk("m_wdata", bus.m_wdata, e1.wdata);
    end
    rc = e2.v && !e2.we && !e2.port;
    rd = e2.v && !e2.we &&  e2.port;
    chk("c_rvalid", bus.c_rvalid, rc);
    chk("d_rvalid", bus.d_rvalid, rd);
    chk("c_rdata",  bus.c_rdata,  rc ? e2.rexp : 8'h00);
    chk("d_rdata",  bus.d_rdata,  rd ? e2.rexp : 8'h00);

    ne.v     = (g != 0);
    ne.port  = (g == 2);
    ne.we    = (g == 2) ? bus.d_we    : bus.c_we;
    ne.addr  = (g == 2) ? bus.d_addr  : bus.c_addr;
    ne.wdata = (g == 2) ? bus.d_wdata : bus.c_wdata;
    ne.rexp  = 8'h00;
    if (ne.v) begin
      if (ne.we) shadow[ne.addr] = ne.wdata;
      ne.rexp = shadow[ne.addr];
      if (both && g == m_holder && m_hold_lock && m_streak < MAXL) m_streak++;
      else m_streak = 0;
      m_hold_lock = (g == 2) ? bus.d_lock : bus.c_lock;
      m_last      = g;
      m_owner     = (g == 2);
    end else begin
      m_streak    = 0;
      m_hold_lock = 1'b0;
    end
    m_holder = g;
    @(posedge clk);
    hist.push_back(ne);
    void'(hist.pop_front());
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.c_req = 0; bus.c_we = 0; bus.c_lock = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_owner",  bus.owner,   0);
    chk("rst_m_en",   bus.m_en,    0);
    chk("rst_m_we",   bus.m_we,    0);
    chk("rst_m_addr", bus.m_addr,  0);
    chk("rst_gnt",    {bus.c_gnt, bus.d_gnt}, 0);
    chk("rst_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    bit          rstb;
    bit          cr, cw, cl;
    logic [15:0] ca;
    logic [7:0]  cd;
    bit          dr, dw, dl;
    logic [15:0] da;
    logic [7:0]  dd;
    logic [1:0]  eg;   // {d_gnt, c_gnt}
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input bit rstb,
                              input bit cr, input bit cw, input bit cl,
                              input logic [15:0] ca, input logic [7:0] cd,
                              input bit dr, input bit dw, input bit dl,
                              input logic [15:0] da, input logic [7:0] dd,
                              input logic [1:0] eg);
    vec_t v;
    v.rstb = rstb; v.cr = cr; v.cw = cw; v.cl = cl; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd; v.eg = eg;
    return v;
  endfunction

  initial begin
    int         g;
    logic [1:0] ag;
    bit         c_hold, d_hold;

    for (int a = 0; a < 65536; a++) shadow[a] = init_val(a);
    model_reset();
    drive_idle();

    //            rst  C: req we lk addr      data   D: req we lk addr      data   {d,c}
    tbl[0]  = mk(1, 1,0,0, 16'h0010, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[1]  = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[2]  = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[3]  = mk(1, 1,0,0, 16'h0100, 8'h00,  1,0,0, 16'h0200, 8'h00, 2'b01);
    tbl[4]  = mk(0, 1,0,0, 16'h0101, 8'h00,  1,0,0, 16'h0200, 8'h00, 2'b10);
    tbl[5]  = mk(0, 1,0,0, 16'h0101, 8'h00,  1,0,0, 16'h0201, 8'h00, 2'b01);
    tbl[6]  = mk(0, 1,0,0, 16'h0102, 8'h00,  1,0,0, 16'h0201, 8'h00, 2'b10);
    tbl[7]  = mk(0, 1,0,0, 16'h0102, 8'h00,  1,0,0, 16'h0202, 8'h00, 2'b01);
    tbl[8]  = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[9]  = mk(0, 0,0,0, 16'h0000, 8'h00,  1,0,0, 16'h0400, 8'h00, 2'b10);
    tbl[10] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[11] = mk(0, 1,0,1, 16'h0300, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b01);
    tbl[12] = mk(0, 1,0,1, 16'h0301, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b01);
    tbl[13] = mk(0, 1,0,1, 16'h0302, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b01);
    tbl[14] = mk(0, 1,0,1, 16'h0303, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b01);
    tbl[15] = mk(0, 1,0,1, 16'h0304, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b01);
    tbl[16] = mk(0, 1,0,1, 16'h0305, 8'h00,  1,1,0, 16'h0500, 8'h77, 2'b10);
    tbl[17] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[18] = mk(0, 0,0,0, 16'h0000, 8'h00,  1,1,0, 16'h1234, 8'hA5, 2'b10);
    tbl[19] = mk(0, 1,0,0, 16'h1234, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[20] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[21] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[22] = mk(0, 1,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[23] = mk(0, 1,0,0, 16'h0001, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[24] = mk(0, 1,0,0, 16'h0002, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[25] = mk(0, 1,0,0, 16'h0003, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b01);
    tbl[26] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[27] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);
    tbl[28] = mk(0, 0,0,0, 16'h0000, 8'h00,  0,0,0, 16'h0000, 8'h00, 2'b00);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rstb) do_reset();
      bus.c_req = tbl[i].cr; bus.c_we = tbl[i].cw; bus.c_lock = tbl[i].cl;
      bus.c_addr = tbl[i].ca; bus.c_wdata = tbl[i].cd;
      bus.d_req = tbl[i].dr; bus.d_we = tbl[i].dw; bus.d_lock = tbl[i].dl;
      bus.d_addr = tbl[i].da; bus.d_wdata = tbl[i].dd;
      // Hand-derived return values for the first read and the read-after-write
      if (i == 2) begin
        chk("t1_c_rvalid", bus.c_rvalid, 1);
        chk("t1_c_rdata",  bus.c_rdata,  8'h5A);
      end
      if (i == 21) begin
        chk("raw_c_rdata",  bus.c_rdata,  8'hA5);
        chk("raw_d_rvalid", bus.d_rvalid, 0);
      end
      step(g, ag);
      chk($sformatf("tbl%0d_gnt", i), ag, tbl[i].eg);
    end

    // ---------------- random traffic -------------------------------------
    c_hold = 1'b0;
    d_hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!c_hold) begin
        bus.c_req   = ($urandom_range(0, 9) < 7);
        bus.c_we    = $urandom_range(0, 1) == 1;
        bus.c_lock  = $urandom_range(0, 2) != 0;
        bus.c_addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        bus.c_wdata = 8'($urandom);
      end
      if (!d_hold) begin
        bus.d_req   = ($urandom_range(0, 9) < 7);
        bus.d_we    = $urandom_range(0, 1) == 1;
        bus.d_lock  = $urandom_range(0, 2) != 0;
        bus.d_addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        bus.d_wdata = 8'($urandom);
      end
      step(g, ag);
      c_hold = bus.c_req && (g != 1);
      d_hold = bus.d_req && (g != 2);
    end

    // ---------------- asynchronous reset with a read at the RAM stage ----
    drive_idle();
    step(g, ag);
    bus.c_req = 1; bus.c_addr = 16'h0007;
    step(g, ag);                 // C granted; read now at the RAM stage
    bus.c_addr = 16'h0008;
    bus.d_req  = 1; bus.d_addr = 16'h0009;
    #1 rst = 1'b0;
    #1;
    chk("arst_c_gnt",    bus.c_gnt,    0);
    chk("arst_d_gnt",    bus.d_gnt,    0);
    chk("arst_m_en",     bus.m_en,     0);
    chk("arst_m_we",     bus.m_we,     0);
    chk("arst_m_addr",   bus.m_addr,   0);
    chk("arst_m_wdata",  bus.m_wdata,  0);
    chk("arst_owner",    bus.owner,    0);
    chk("arst_c_rvalid", bus.c_rvalid, 0);
    chk("arst_c_rdata",  bus.c_rdata,  0);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(g, ag);
    step(g, ag);
    bus.c_req = 1; bus.c_addr = 16'h0020;
    bus.d_req = 1; bus.d_addr = 16'h0021;
    step(g, ag);
    chk("post_rst_tie", ag, 2'b01);
    drive_idle();
    repeat (3) step(g, ag);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 64K x 8 program/data memory between two requesters: port C (CPU core fetch/execute) and port D (loader/debug master that preloads or inspects memory).
- Round-robin arbitration with a bounded lock, so CPU read-modify-write sequences (ADD_CM_R, SUB_CM_R) stay atomic.
- Drives a synchronous single-port RAM with 1-cycle read latency.
- Pipelined: one access per clock.

Parameters:
- AW, 16, address width
- DW, 8, data width
- MAX_LOCK, 4, max consecutive locked grants to one port while the other port is waiting

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- c_req  in  1  port C request, held until c_gnt
- c_we  in  1  port C write (1) / read (0)
- c_lock  in  1  port C asks to keep ownership for the next access
- c_addr  in  AW  port C address
- c_wdata  in  DW  port C write data
- c_gnt  out  1  port C request accepted this cycle
- c_rvalid  out  1  port C read data valid
- c_rdata  out  DW  port C read data
- d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as port C, for port D
- m_en  out  1  RAM enable
- m_we  out  1  RAM write enable
- m_addr  out  AW  RAM address
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data, valid 1 cycle after m_en with m_we=0
- owner  out  1  port of the last grant (0=C, 1=D)

Behaviour:
- Reset (rst=0, async) forces these values to 0: gnt, rvalid, m_en, m_we, m_addr, m_wdata, owner, lock counter.
  - FSM goes to IDLE; last-granted pointer is set to D, so C wins the first tie.
  - Reset mid-operation drops any in-flight read; no rvalid appears after rst is released.
- FSM states: IDLE (no grant last cycle), OWN_C, OWN_D. The state is the registered result of the cycle's grant.
- Grant decision is combinational in cycle N, from req/lock and the registered state.
  - Only one requesting port: it is granted.
  - Both requesting, current owner's lock_q=1 and lock_cnt<MAX_LOCK: owner is granted again.
  - Otherwise: round-robin, the port not granted last wins.
  - No request: next state IDLE, no gnt.
- lock_q is the lock input of the granted port, sampled at grant. Lock is ignored when the granting port differs from the current owner.
- lock_cnt:
  - increments on each locked re-grant while the other port is requesting;
  - clears on an ownership change or when the other port is idle;
  - saturates at MAX_LOCK, which forces a handover at the next conflict.
- Issue: in cycle N+1, m_en=1 and m_we/m_addr/m_wdata are registered copies of the granted port's fields. m_en=0 when there was no grant in N.
- Read return:
  - In cycle N+2, the granted port's rvalid=1 and its rdata = m_rdata. Other port's rdata = 0.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid on consecutive cycles in grant order.
- Requester protocol:
  - A request stays stable until gnt.
  - A new request may be presented in the cycle after gnt; its data is registered, so a changing input is harmless.
  - A request dropped without gnt is simply not served.
- Read-after-write to the same address from either port returns the new data (RAM is write-first; the arbiter serialises).
- Address wrap is not handled; full 2^AW range passes through unchanged.
- owner updates on every grant and holds during IDLE.

Test Plan:
- Reset then C read of addr 0x0010 (RAM holds 0x5A): c_gnt in cycle 1; m_en=1, m_addr=0x0010 in cycle 2; c_rvalid=1, c_rdata=0x5A in cycle 3; d_rvalid stays 0.
- C and D request every cycle, no lock: grants alternate C,D,C,D starting with C; owner toggles each cycle.
- C holds c_lock=1 with D requesting, MAX_LOCK=4: C granted 5 consecutive times (1 initial + 4 re-grants), then D granted; lock_cnt returns to 0.
- D writes 0xA5 to 0x1234, then C reads 0x1234 the next cycle: c_rdata=0xA5, and no rvalid is generated for the write.
- Pipelined C reads of 0x0000..0x0003: c_rvalid high 4 consecutive cycles, data in address order.
- Assert rst=0 asynchronously while a read is at the RAM stage: all outputs go 0 immediately; no c_rvalid after release; first post-reset tie goes to C.
